control_demux: RTL and testbench

Flow-controlled sequencer for the 4-way `demux` datapath. It accepts words from the upstream stage through a valid/ready handshake and decodes the 2-bit destination field carried in each word. It holds the word until the destination FIFO can take it, then drives the demux `selector`, `enb` and data for exactly one cycle. It sits between the serial input stage and the four per-channel FIFOs, and is the only block that generates the demux controls.

---
 rtl/demux_pkg.sv | 18 +
 rtl/contador_salida.sv | 18 +
 rtl/control_demux.sv | 92 +++++++++
 tb/tb_control_demux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared encodings for the 4-way demux: selector codes, sequencer states and
// destination field width.
package demux_pkg;
  localparam int DEST_W = 2;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    VACIO     = 2'b00,
    LLENO     = 2'b01,
    BLOQUEADO = 2'b10
  } estado_e;
endpackage

// File: rtl/contador_salida.sv
// Per-output delivered-word counter; wraps from all-ones back to zero.
module contador_salida #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enb,
  output logic [CNT_BITS-1:0] o_cuenta
);
  logic [CNT_BITS-1:0] r_cuenta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_cuenta <= '0;
    else if (i_enb) r_cuenta <= r_cuenta + 1'b1;
  end

  assign o_cuenta = r_cuenta;
endmodule

// File: rtl/control_demux.sv
// Flow-controlled sequencer driving the 4-way demux from a single holding register.
// Define CONTROL_DEMUX_CONTADORES_EN to build the per-output word counters.
module control_demux
  import demux_pkg::*;
#(
  parameter int DATA_BITS = 6,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entrada_valid,
  input  logic [DATA_BITS-1:0] entrada,
  output logic                 entrada_ready,
  input  logic [3:0]           fifo_almost_full,
  output logic [1:0]           selector,
  output logic                 enb,
  output logic [DATA_BITS-1:0] dato_salida,
  output logic                 bloqueado,
  output logic [CNT_BITS-1:0]  cuenta0,
  output logic [CNT_BITS-1:0]  cuenta1,
  output logic [CNT_BITS-1:0]  cuenta2,
  output logic [CNT_BITS-1:0]  cuenta3
);
  logic                 r_hold;
  logic [DATA_BITS-1:0] r_dato_hold;
  logic [DEST_W-1:0]    r_dest_hold;
  logic                 r_enb;
  logic [1:0]           r_selector;
  logic [DATA_BITS-1:0] r_dato_salida;

  estado_e w_estado;
  logic    w_emit;
  logic    w_xfer;
  logic [3:0][CNT_BITS-1:0] w_cuenta;

  // State follows the live almost-full of the held word's target every cycle.
  always_comb begin
    w_estado = VACIO;
    if (r_hold) w_estado = fifo_almost_full[r_dest_hold] ? BLOQUEADO : LLENO;
  end

  assign w_emit        = (w_estado == LLENO);
  assign entrada_ready = (w_estado == VACIO) || w_emit;
  assign bloqueado     = (w_estado == BLOQUEADO);
  assign w_xfer        = entrada_valid && entrada_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold        <= 1'b0;
      r_dato_hold   <= '0;
      r_dest_hold   <= '0;
      r_enb         <= 1'b0;
      r_selector    <= S0;
      r_dato_salida <= '0;
    end else begin
      r_enb <= w_emit;
      if (w_emit) begin
        r_selector    <= r_dest_hold;
        r_dato_salida <= r_dato_hold;
      end
      if (w_xfer) begin
        r_hold      <= 1'b1;
        r_dato_hold <= entrada;
        r_dest_hold <= entrada[DATA_BITS-1 -: DEST_W];
      end else if (w_emit) begin
        r_hold <= 1'b0;
      end
    end
  end

  assign enb         = r_enb;
  assign selector    = r_selector;
  assign dato_salida = r_dato_salida;

`ifdef CONTROL_DEMUX_CONTADORES_EN
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    contador_salida #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .i_enb    (r_enb && (r_selector == i[1:0])),
      .o_cuenta (w_cuenta[i])
    );
  end
`else
  assign w_cuenta = '0;
`endif

  assign cuenta0 = w_cuenta[0];
  assign cuenta1 = w_cuenta[1];
  assign cuenta2 = w_cuenta[2];
  assign cuenta3 = w_cuenta[3];
endmodule

// File: tb/tb_control_demux.sv
// Directed bench for control_demux; counter expectations follow CONTROL_DEMUX_CONTADORES_EN.
module tb_control_demux;
  localparam int DATA_BITS = 6;
  localparam int CNT_BITS  = 8;
`ifdef CONTROL_DEMUX_CONTADORES_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 entrada_valid;
  logic [DATA_BITS-1:0] entrada;
  logic                 entrada_ready;
  logic [3:0]           fifo_almost_full;
  logic [1:0]           selector;
  logic                 enb;
  logic [DATA_BITS-1:0] dato_salida;
  logic                 bloqueado;
  logic [CNT_BITS-1:0]  cuenta0, cuenta1, cuenta2, cuenta3;

  int n_chk  = 0;
  int n_pass = 0;

  control_demux #(.DATA_BITS(DATA_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk              (clk),
    .reset            (reset),
    .entrada_valid    (entrada_valid),
    .entrada          (entrada),
    .entrada_ready    (entrada_ready),
    .fifo_almost_full (fifo_almost_full),
    .selector         (selector),
    .enb              (enb),
    .dato_salida      (dato_salida),
    .bloqueado        (bloqueado),
    .cuenta0          (cuenta0),
    .cuenta1          (cuenta1),
    .cuenta2          (cuenta2),
    .cuenta3          (cuenta3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e, input logic [1:0] s, input logic [5:0] d);
    chk({tag, ".enb"}, enb, e);
    chk({tag, ".sel"}, selector, s);
    chk({tag, ".dato"}, dato_salida, d);
  endtask

  task automatic chk_cnt(input string tag, input int c0, input int c1, input int c2, input int c3);
    chk({tag, ".c0"}, cuenta0, CNT_EN ? c0 : 0);
    chk({tag, ".c1"}, cuenta1, CNT_EN ? c1 : 0);
    chk({tag, ".c2"}, cuenta2, CNT_EN ? c2 : 0);
    chk({tag, ".c3"}, cuenta3, CNT_EN ? c3 : 0);
  endtask

  logic [5:0] w_str [4] = '{6'b00_0001, 6'b01_0010, 6'b10_0011, 6'b11_0100};
  logic [5:0] w_nt  [3] = '{6'b00_0101, 6'b00_0110, 6'b00_0111};

  initial begin
    reset = 1'b1; entrada_valid = 1'b0; entrada = '0; fifo_almost_full = 4'b0000;
    #1;
    chk("rst.ready", entrada_ready, 1'b1);
    chk("rst.bloq", bloqueado, 1'b0);
    chk_out("rst", 1'b0, 2'd0, 6'd0);
    chk_cnt("rst", 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // streaming, 1 word/cycle, selector 0..3
    entrada_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      entrada = w_str[i];
      tick();
      if (i > 0) chk_out("str", 1'b1, w_str[i-1][5:4], w_str[i-1]);
    end
    entrada_valid = 1'b0;
    tick();
    chk_out("str3", 1'b1, 2'd3, w_str[3]);
    tick();
    chk("str.end.enb", enb, 1'b0);
    chk_cnt("str", 1, 1, 1, 1);

    // blocking on target FIFO 2
    fifo_almost_full = 4'b0100;
    entrada_valid = 1'b1; entrada = 6'b10_1010;
    tick();
    entrada_valid = 1'b0;
    chk("blk.bloq", bloqueado, 1'b1);
    chk("blk.ready", entrada_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("blk.enb", enb, 1'b0);
    end
    fifo_almost_full = 4'b0000;
    #1;
    chk("blk.rel.bloq", bloqueado, 1'b0);
    chk("blk.rel.ready", entrada_ready, 1'b1);
    tick();
    chk_out("blk.emit", 1'b1, 2'd2, 6'b101010);
    tick();
    chk("blk.pulse", enb, 1'b0);

    // non-target FIFOs full do not stall destination 0
    fifo_almost_full = 4'b1110;
    entrada_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      entrada = w_nt[i];
      #1;
      chk("nt.ready", entrada_ready, 1'b1);
      chk("nt.bloq", bloqueado, 1'b0);
      tick();
      if (i > 0) chk_out("nt", 1'b1, 2'd0, w_nt[i-1]);
    end
    entrada_valid = 1'b0;
    tick();
    chk_out("nt2", 1'b1, 2'd0, w_nt[2]);
    tick();
    chk("nt.end.enb", enb, 1'b0);
    fifo_almost_full = 4'b0000;

    // strict order while destination 1 is blocked
    fifo_almost_full = 4'b0010;
    entrada_valid = 1'b1; entrada = 6'b01_0001;
    tick();
    entrada = 6'b00_0010;
    #1;
    chk("ord.ready", entrada_ready, 1'b0);
    chk("ord.bloq", bloqueado, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ord.enb", enb, 1'b0);
      chk("ord.stall", entrada_ready, 1'b0);
    end
    fifo_almost_full = 4'b0000;
    #1;
    chk("ord.rel.ready", entrada_ready, 1'b1);
    tick();
    entrada_valid = 1'b0;
    chk_out("ord.first", 1'b1, 2'd1, 6'b010001);
    tick();
    chk_out("ord.second", 1'b1, 2'd0, 6'b000010);
    tick();
    chk("ord.end.enb", enb, 1'b0);
    chk_cnt("pre", 5, 2, 2, 1);

    // asynchronous reset while enb is high and a word is held
    entrada_valid = 1'b1; entrada = 6'b11_0111;
    tick();
    entrada = 6'b11_0001;
    tick();
    entrada_valid = 1'b0;
    chk("ar.enb.pre", enb, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("ar.ready", entrada_ready, 1'b1);
    chk("ar.bloq", bloqueado, 1'b0);
    chk_out("ar", 1'b0, 2'd0, 6'd0);
    chk_cnt("ar", 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar.discard", enb, 1'b0);

    // wrap: 257 words to output 3
    entrada_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      entrada = {2'b11, 4'(i)};
      tick();
    end
    entrada_valid = 1'b0;
    tick();
    tick();
    chk_cnt("wrap", 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
